// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector with two internal line buffers.
// Produces one result per interior pixel in binary-threshold or saturated-magnitude mode.
module sobel_stream_filter #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 3;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [GW-1:0] MAX_VAL  = {3'b000, {DATA_W{1'b1}}};

  logic [CW-1:0]     col, cur_col;
  logic [RW-1:0]     row, cur_row;
  logic [DATA_W-1:0] thr_q;
  logic              mode_q;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  logic [DATA_W-1:0] win [3][3];
  logic              s1_valid, s1_last, s1_mode;
  logic [DATA_W-1:0] s1_thr;

  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
  logic                 s2_valid, s2_last, s2_mode;
  logic [DATA_W-1:0]    s2_thr;

  logic [GW-1:0]     abs_x, abs_y, mag;
  logic [DATA_W-1:0] sat_mag, result;

  // A start-of-frame pixel is placed at (0,0) regardless of where the counters are.
  assign cur_col = pix_sof ? '0 : col;
  assign cur_row = pix_sof ? '0 : row;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      col    <= '0;
      row    <= '0;
      thr_q  <= '0;
      mode_q <= 1'b0;
    end else if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
      if (cur_col == '0 && cur_row == '0) begin
        thr_q  <= threshold;
        mode_q <= mode;
      end
    end
  end

  assign lb1_rd = lb1[cur_col];
  assign lb2_rd = lb2[cur_col];

  always_ff @(posedge sys_clk) begin
    if (pix_valid) begin
      lb1[cur_col] <= pix_data;
      lb2[cur_col] <= lb1_rd;
    end
  end

  // S1: shift the window; threshold/mode travel with each result so a frame
  // change does not alter outputs of the previous frame still in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_thr   <= '0;
      s1_mode  <= 1'b0;
    end else begin
      s1_valid <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      s1_thr   <= thr_q;
      s1_mode  <= mode_q;
      if (pix_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= pix_data;
        s1_last   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      end
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  always_comb begin
    gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gx_q     <= '0;
      gy_q     <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_thr   <= '0;
      s2_mode  <= 1'b0;
    end else begin
      gx_q     <= gx_c;
      gy_q     <= gy_c;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_thr   <= s1_thr;
      s2_mode  <= s1_mode;
    end
  end

  // Binary mode compares the unsaturated magnitude against the threshold.
  always_comb begin
    abs_x   = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y   = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag     = abs_x + abs_y;
    sat_mag = (mag > MAX_VAL) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    if (s2_mode)
      result = sat_mag;
    else
      result = (mag >= {3'b000, s2_thr}) ? {DATA_W{1'b1}} : '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      out_data  <= s2_valid ? result : '0;
      out_last  <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter on an 8x6 frame: the driver queues
// hand-derived results per completing pixel, a monitor checks value, last flag and arrival cycle.
module tb_sobel_stream_filter;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [DW-1:0] threshold = '0;
  logic          mode = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   obs_cnt = 0;
  int   cyc = 0;

  sobel_stream_filter #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .pix_valid(pix_valid),
    .pix_sof  (pix_sof),
    .pix_data (pix_data),
    .threshold(threshold),
    .mode     (mode),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Kind 0 is a constant image (all gradients zero); kind 1 is a vertical step
  // of height v at column 4, so only centres at columns 3 and 4 see gx = 4*v.
  function automatic logic [DW-1:0] expect_val(input int kind, input int v, input int c,
                                               input logic md, input logic [DW-1:0] thr);
    int mag;
    mag = (kind == 1 && (c == 3 || c == 4)) ? 4 * v : 0;
    if (md) return (mag > 255) ? 8'd255 : 8'(mag);
    return (mag >= int'(thr)) ? 8'hFF : 8'h00;
  endfunction

  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1) begin
      obs_cnt++;
      if (q.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("out_last", 32'(out_last), 32'(e.last));
        checkOutput("arrival_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drives one frame (optionally cut short after stop_row/stop_col). Off the
  // first pixel, threshold/mode are driven to wrong values to prove latching.
  task automatic applyStimulus(input int kind, input int v, input logic md, input logic [DW-1:0] thr,
                               input logic use_sof, input logic gaps, input int stop_row, input int stop_col);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r > stop_row || (r == stop_row && c > stop_col)) return;
        if (gaps) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge sys_clk); #1;
            pix_valid = 1'b0;
            pix_sof   = 1'b1;
            pix_data  = 8'($urandom);
          end
        end
        @(posedge sys_clk); #1;
        pix_valid = 1'b1;
        pix_sof   = use_sof && r == 0 && c == 0;
        pix_data  = (kind == 0 || c >= 4) ? 8'(v) : 8'd0;
        if (r == 0 && c == 0) begin
          threshold = thr;
          mode      = md;
        end else begin
          threshold = ~thr;
          mode      = ~md;
        end
        if (r >= 2 && c >= 2)
          q.push_back(exp_t'{expect_val(kind, v, c - 1, md, thr), (r == H - 1 && c == W - 1), cyc + 3});
      end
    end
  endtask

  task automatic drain_and_check(input string name, input int want_obs);
    @(posedge sys_clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    checkOutput({name, "_pending"}, 32'(q.size()), 32'd0);
    checkOutput({name, "_out_count"}, 32'(obs_cnt), 32'(want_obs));
    q.delete();
    obs_cnt = 0;
  endtask

  task automatic pulse_reset();
    @(posedge sys_clk); #1;
    sys_rst   = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    q.delete();
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    obs_cnt = 0;
  endtask

  initial begin
    #1 sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_last", 32'(out_last), 32'd0);
    sys_rst = 1'b0;

    $display("[TB] constant image, magnitude mode");
    applyStimulus(0, 50, 1'b1, 8'd0, 1'b1, 1'b0, H, 0);
    drain_and_check("const", 24);

    $display("[TB] vertical step of 20, magnitude mode");
    applyStimulus(1, 20, 1'b1, 8'd0, 1'b1, 1'b0, H, 0);
    drain_and_check("step20", 24);

    $display("[TB] binary mode thr 80 then back-to-back frame thr 81 by natural wrap");
    applyStimulus(1, 20, 1'b0, 8'd80, 1'b1, 1'b0, H, 0);
    applyStimulus(1, 20, 1'b0, 8'd81, 1'b0, 1'b0, H, 0);
    drain_and_check("thr", 48);

    $display("[TB] step of 200, saturation");
    applyStimulus(1, 200, 1'b1, 8'd0, 1'b1, 1'b0, H, 0);
    drain_and_check("sat", 24);

    $display("[TB] step of 20 with random input gaps");
    applyStimulus(1, 20, 1'b1, 8'd0, 1'b1, 1'b1, H, 0);
    drain_and_check("gaps", 24);

    $display("[TB] frame abandoned at row 3 col 5 by start-of-frame");
    applyStimulus(1, 20, 1'b1, 8'd0, 1'b1, 1'b0, 3, 5);
    applyStimulus(1, 200, 1'b1, 8'd0, 1'b1, 1'b0, H, 0);
    drain_and_check("sof", 34);

    $display("[TB] reset pulsed mid-frame");
    applyStimulus(0, 50, 1'b1, 8'd0, 1'b1, 1'b0, 4, 4);
    pulse_reset();
    applyStimulus(1, 20, 1'b0, 8'd10, 1'b0, 1'b0, H, 0);
    drain_and_check("rst", 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream_filter.md
# sobel_stream_filter

Parametrised streaming 3x3 Sobel edge detector for the DDR3→HDMI video path: accepts one grayscale pixel per valid cycle in raster order, buffers two lines internally and emits the gradient result for every interior pixel. Successor to the fixed 640x480 / 8-bit Sobel controller. It adds parametrised frame geometry and pixel width, a start-of-frame resync, per-frame runtime threshold and mode (binary edge map or saturated magnitude), and an end-of-frame marker. It sits between the grayscale converter and the frame-buffer write side.

## Interface
- DATA_W, 8, pixel width in bits (input and output)
- IMG_W, 640, pixels per line (≥4)
- IMG_H, 480, lines per frame (≥3)
- sys_clk  input  1  single clock, all logic on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- pix_valid  input  1  pixel present this cycle; no backpressure, gaps allowed
- pix_sof  input  1  qualifies pix_valid: pixel is row 0, col 0 of a new frame
- pix_data  input  DATA_W  grayscale pixel
- threshold  input  DATA_W  binary-mode threshold, latched at frame start
- mode  input  1  0 = binary edge map, 1 = magnitude; latched at frame start
- out_valid  output  1  out_data valid this cycle
- out_data  output  DATA_W  result for the current window centre
- out_last  output  1  with out_valid: last interior pixel of the frame

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on pix_valid. col wraps to 0 and increments row. row wraps after IMG_H-1, so frame N+1 starts without pix_sof.
- pix_sof & pix_valid forces the accepted pixel to (row 0, col 0), wherever the counters were. Counters then continue from col 1. threshold and mode are latched into thr_q/mode_q on this pixel. They are also latched on any pixel accepted at (0,0) by natural wrap.
- Line buffers: two RAMs of IMG_W x DATA_W hold rows r-1 and r-2, both addressed by col. Each accepted pixel reads both RAMs at col, then writes pix_data into row r-1 and the old row r-1 value into row r-2.
- Window: a 3x3 register array shifts left on each accepted pixel. The new right column is {row r-2, row r-1, pix_data}.
- The window is complete when the accepted pixel has row ≥ 2 and col ≥ 2. Its centre is (row-1, col-1). Only these pixels produce output: (IMG_W-2)*(IMG_H-2) outputs per frame. Border pixels produce nothing.
- Gradients use unsigned pixels zero-extended to signed DATA_W+3 bits:
  - gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - p[row][col], row 0 = oldest line.
- mag = |gx| + |gy|, computed in DATA_W+3 bits and saturated to 2^DATA_W−1.
- mode_q=1: out_data = saturated mag.
- mode_q=0: out_data = all-ones when mag ≥ thr_q, else all-zeros.
- out_last = 1 for the output whose centre is (IMG_H-2, IMG_W-2).

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, counters 0, window 0, pipeline valids 0, thr_q=0, mode_q=0. Line-buffer RAM contents are not reset.
- Pipeline is 3 stages and advances every cycle, independent of pix_valid:
  - S1: window update and complete flag.
  - S2: gx/gy registered.
  - S3: magnitude, saturate, compare, output registers.
- A completing pixel accepted at cycle T gives out_valid at T+3, exactly one cycle wide. Input gaps never stall or drop in-flight results.
- Throughput is one output per cycle when pix_valid is continuously high.
- pix_sof mid-frame: up to 3 in-flight outputs still emerge unchanged. The new frame then emits nothing until its row 2, col 2. out_last is not produced for the abandoned frame.
- The threshold/mode latch takes effect for the first output of the frame. The last outputs of the previous frame (still in S2/S3) use the old values.
- sys_rst asserted mid-frame clears all outputs asynchronously and discards in-flight results. After release, the first accepted pixel is treated as (0,0).

## Test plan
- DATA_W=8, IMG_W=8, IMG_H=6, constant image of 50s, mode=1: exactly 24 out_valid pulses, all out_data=0, out_last only on the 24th.
- Vertical step, cols 0-3 = 0 and cols 4-7 = 20, mode=1: each output row reads 0,0,80,80,0,0 (centre cols 1..6).
- Same image, mode=0, threshold=80 → 0,0,255,255,0,0. Next frame with threshold=81 → all 0. Confirm the new threshold takes effect only from that frame's first output.
- Step of 200, mode=1: gx=800 saturates, giving out_data=255 at centre cols 3 and 4.
- Continuous input with 1-3 cycle random gaps: outputs match the gap-free reference, each arriving exactly 3 cycles after its completing pixel.
- Two cases, frame restart and reset:
  - pix_sof at row 3, col 5 of a frame: in-flight outputs drain, then 24 outputs for the new frame with correct values.
  - sys_rst pulsed mid-frame: out_valid=0 immediately, and the next full frame is correct.
